// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: fetcher FSM states, display mode encoding, default geometry.
// Latency: none (types and constants only).
// Backpressure: none.
//
// The geometry constants are shared with the renderer so both sides agree on
// how many ship records there are and how wide each one is.
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } fetch_state_e;

  typedef enum logic {
    MODE_POS  = 1'b0,
    MODE_EXEC = 1'b1
  } vga_mode_e;

  localparam int VGA_NUM_SHIPS = 11;
  localparam int VGA_DATA_W    = 64;
  localparam int VGA_ADDR_W    = 5;

  // True while reads are being issued or are still in flight.
  function automatic logic in_sweep(input fetch_state_e s);
    return (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/vga_rd_pipe.sv
// Tracks outstanding memory reads: a RD_LAT-deep shift register of {valid, index}.
// Latency: an entry presented at in_* appears at out_* exactly RD_LAT cycles later.
// Backpressure: none; flush drops every in-flight entry (including the one being presented).
//
// Ports: clk/rst_n (async active-low), flush, in_vld/in_idx (read issued this
// cycle), out_vld/out_idx (matching read data is on the memory bus this cycle).
module vga_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_idx,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_idx
);

  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = '0;
    idx_d    = idx_q;
    vld_d[0] = in_vld & ~flush;
    idx_d[0] = in_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1] & ~flush;
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_idx = idx_q[RD_LAT-1];

endmodule

// File: rtl/vga_ship_fetch.sv
// Per-frame fetch of NUM_SHIPS ship records into a shadow buffer, committed atomically to ship_data.
// Latency: frame_start to frame_done/ship_data update is NUM_SHIPS + RD_LAT + 1 cycles.
// Backpressure: none; a frame_start during a sweep is dropped and flagged on fetch_overrun.
//
// Ports: clk, resetGeral (async active-low); ready*/jogador* select mode and
// player; frame_start starts a sweep; mem_rd/mem_addr/mem_data talk to the
// selected player's position memory (data RD_LAT cycles after mem_rd);
// jogadorVGA, exibeMapa, ship_data, frame_done, fetch_overrun feed the renderer.
// All outputs are registered.
//
// Build option VGA_SHIP_FETCH_CLEAR_ON_IDLE_EN: when defined, entering IDLE
// zeroes ship_data and the shadow buffer; otherwise the last sweep is kept.
module vga_ship_fetch
  import vga_pkg::*;
#(
  parameter int NUM_SHIPS = VGA_NUM_SHIPS,
  parameter int DATA_W    = VGA_DATA_W,
  parameter int ADDR_W    = VGA_ADDR_W,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        resetGeral,
  input  logic                        readyPosicionandoPecas,
  input  logic                        readyExecutandoJogo,
  input  logic                        jogadorPosicionandoPecas,
  input  logic                        jogadorExecutandoJogo,
  input  logic                        frame_start,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        jogadorVGA,
  output logic                        exibeMapa,
  output logic [NUM_SHIPS*DATA_W-1:0] ship_data,
  output logic                        frame_done,
  output logic                        fetch_overrun
);

  localparam int              SHIP_W   = NUM_SHIPS * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SHIPS - 1);

`ifdef VGA_SHIP_FETCH_CLEAR_ON_IDLE_EN
  localparam logic CLEAR_ON_IDLE = 1'b1;
`else
  localparam logic CLEAR_ON_IDLE = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  vga_mode_e         mode_q, mode_d;
  logic              jog_q, jog_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              exibe_q, exibe_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [SHIP_W-1:0] shadow_q, shadow_d;
  logic [SHIP_W-1:0] ship_q, ship_d;

  logic              active_rdy;
  logic              active_jog;
  logic              player_chg;
  logic              last_addr;
  logic              last_cap;
  logic              flush;
  logic              cap_vld;
  logic              cap_en;
  logic [ADDR_W-1:0] cap_idx;

  // Ready/player of whichever mode was latched when we left IDLE.
  assign active_rdy = (mode_q == MODE_POS) ? readyPosicionandoPecas : readyExecutandoJogo;
  assign active_jog = (mode_q == MODE_POS) ? jogadorPosicionandoPecas : jogadorExecutandoJogo;
  assign player_chg = (active_jog != jog_q);
  assign last_addr  = (mem_addr_q == LAST_IDX);
  // The final record is on the bus this cycle, so the commit edge can take it directly.
  assign last_cap   = cap_vld && (cap_idx == LAST_IDX);

  // Read tracker: the registered read strobe/address enter the pipe, so its
  // output lines up with the RD_LAT-delayed memory data.
  vga_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (resetGeral),
    .flush   (flush),
    .in_vld  (mem_rd_q),
    .in_idx  (mem_addr_q),
    .out_vld (cap_vld),
    .out_idx (cap_idx)
  );

  // State register
  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Losing the active ready beats everything else; a
  // player change beats starting or finishing a sweep.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (readyPosicionandoPecas || readyExecutandoJogo) begin
        state_d = ST_ARMED;
      end
    end else if (!active_rdy) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (!player_chg && frame_start) state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (player_chg)     state_d = ST_ARMED;
          else if (last_addr) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (player_chg)    state_d = ST_ARMED;
          else if (last_cap) state_d = ST_COMMIT;
        end
        ST_COMMIT: state_d = ST_ARMED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values, all keyed off the transition being taken.
  always_comb begin
    mode_d     = mode_q;
    jog_d      = jog_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    exibe_d    = exibe_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    shadow_d   = shadow_q;
    ship_d     = ship_q;

    // Landing in IDLE or ARMED means any reads still in flight belong to an
    // abandoned sweep (after a commit the pipe is already empty).
    flush  = (state_d == ST_IDLE) || (state_d == ST_ARMED);
    cap_en = cap_vld && !flush;

    if (state_q == ST_IDLE && state_d == ST_ARMED) begin
      if (readyPosicionandoPecas) begin
        mode_d = MODE_POS;
        jog_d  = jogadorPosicionandoPecas;
      end else begin
        mode_d = MODE_EXEC;
        jog_d  = jogadorExecutandoJogo;
      end
    end

    // The map on screen belongs to the old player: follow the new one and hide it.
    if (state_q != ST_IDLE && active_rdy && player_chg) begin
      jog_d   = active_jog;
      exibe_d = 1'b0;
    end

    if (state_d == ST_ISSUE) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = (state_q == ST_ISSUE) ? mem_addr_q + 1'b1 : '0;
    end

    if (cap_en) begin
      shadow_d[int'(cap_idx)*DATA_W +: DATA_W] = mem_data;
    end

    if (frame_start && (in_sweep(state_q) || state_q == ST_COMMIT)) begin
      ovr_d = 1'b1;
    end

    // shadow_d already holds the last record captured on this same edge.
    if (state_d == ST_COMMIT) begin
      ship_d  = shadow_d;
      done_d  = 1'b1;
      exibe_d = 1'b1;
    end

    if (state_d == ST_IDLE) begin
      exibe_d = 1'b0;
      ovr_d   = 1'b0;
      if (CLEAR_ON_IDLE && state_q != ST_IDLE) begin
        shadow_d = '0;
        ship_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      mode_q     <= MODE_POS;
      jog_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      exibe_q    <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      shadow_q   <= '0;
      ship_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      jog_q      <= jog_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      exibe_q    <= exibe_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      shadow_q   <= shadow_d;
      ship_q     <= ship_d;
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign jogadorVGA    = jog_q;
  assign exibeMapa     = exibe_q;
  assign ship_data     = ship_q;
  assign frame_done    = done_q;
  assign fetch_overrun = ovr_q;

endmodule

// File: tb/tb_vga_ship_fetch.sv
// Bench for vga_ship_fetch: default instance (11 ships, RD_LAT 1) plus a 4-ship, RD_LAT 3 instance.
// Memories are behavioural arrays with the right read latency; expected maps are array snapshots.
// Random memory contents and idle gaps come from $urandom.
module tb_vga_ship_fetch;

  localparam int NA = 11;
  localparam int RA = 1;
  localparam int NB = 4;
  localparam int RB = 3;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic a_rdy_pos, a_rdy_exec, a_jog_pos, a_jog_exec, a_fs;
  logic [DW-1:0] a_mem_data = '0;
  logic a_mem_rd, a_jog_vga, a_exibe, a_done, a_ovr;
  logic [AW-1:0] a_mem_addr;
  logic [NA*DW-1:0] a_ship;

  logic b_rdy_pos, b_rdy_exec, b_jog_pos, b_jog_exec, b_fs;
  logic [DW-1:0] b_mem_data = '0;
  logic [DW-1:0] b_p1 = '0, b_p2 = '0;
  logic b_mem_rd, b_jog_vga, b_exibe, b_done, b_ovr;
  logic [AW-1:0] b_mem_addr;
  logic [NB*DW-1:0] b_ship;

  vga_ship_fetch dut_a (
    .clk(clk), .resetGeral(rst_n),
    .readyPosicionandoPecas(a_rdy_pos), .readyExecutandoJogo(a_rdy_exec),
    .jogadorPosicionandoPecas(a_jog_pos), .jogadorExecutandoJogo(a_jog_exec),
    .frame_start(a_fs), .mem_data(a_mem_data), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr),
    .jogadorVGA(a_jog_vga), .exibeMapa(a_exibe), .ship_data(a_ship),
    .frame_done(a_done), .fetch_overrun(a_ovr)
  );

  vga_ship_fetch #(.NUM_SHIPS(NB), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RB)) dut_b (
    .clk(clk), .resetGeral(rst_n),
    .readyPosicionandoPecas(b_rdy_pos), .readyExecutandoJogo(b_rdy_exec),
    .jogadorPosicionandoPecas(b_jog_pos), .jogadorExecutandoJogo(b_jog_exec),
    .frame_start(b_fs), .mem_data(b_mem_data), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
    .jogadorVGA(b_jog_vga), .exibeMapa(b_exibe), .ship_data(b_ship),
    .frame_done(b_done), .fetch_overrun(b_ovr)
  );

  // Per-player position memories; garbage on the bus whenever no read is due.
  logic [DW-1:0] mem_a [2][32];
  logic [DW-1:0] mem_b [2][32];

  always @(posedge clk) begin
    a_mem_data <= a_mem_rd ? mem_a[a_jog_vga][a_mem_addr] : {$urandom, $urandom};
    b_p1       <= b_mem_rd ? mem_b[b_jog_vga][b_mem_addr] : {$urandom, $urandom};
    b_p2       <= b_p1;
    b_mem_data <= b_p2;
  end

  int a_done_cnt = 0;
  always @(negedge clk) if (a_done) a_done_cnt++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_a [NA];
  bit mode_pos;

  task automatic fill_a(input int p);
    for (int i = 0; i < 32; i++) mem_a[p][i] = {$urandom, $urandom};
  endtask

  task automatic take_a(input int p);
    for (int i = 0; i < NA; i++) exp_a[i] = mem_a[p][i];
  endtask

  task automatic clear_exp_on_idle();
`ifdef VGA_SHIP_FETCH_CLEAR_ON_IDLE_EN
    for (int i = 0; i < NA; i++) exp_a[i] = '0;
`endif
  endtask

  task automatic check_ship_a(input string tag);
    for (int i = 0; i < NA; i++)
      chk($sformatf("%s_rec%0d", tag, i), a_ship[i*DW +: DW], exp_a[i]);
  endtask

  // One frame_start on A, then watch. j=1 is the first cycle after the strobe is taken.
  // drop_at/tog_at/fs2_at: cycle in which the active ready drops, the active player
  // toggles, or a second strobe is driven (0 = never).
  task automatic sweep_a(input int drop_at, input int tog_at, input int fs2_at,
                         output int nrd, output int nseq, output int jdone);
    nrd = 0; nseq = 0; jdone = 0;
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    for (int j = 1; j <= NA + RA + 6; j++) begin
      if (a_mem_rd) begin
        nrd++;
        if (int'(a_mem_addr) == j - 1) nseq++;
      end
      if (a_done && jdone == 0) jdone = j;
      if (j == drop_at) begin
        if (mode_pos) a_rdy_pos = 1'b0; else a_rdy_exec = 1'b0;
      end
      if (j == tog_at) begin
        if (mode_pos) a_jog_pos = ~a_jog_pos; else a_jog_exec = ~a_jog_exec;
      end
      a_fs = (j == fs2_at);
      tick();
    end
    a_fs = 1'b0;
  endtask

  task automatic full_sweep_a(input string tag, input int p);
    int nrd, nseq, jd, c0;
    c0 = a_done_cnt;
    sweep_a(0, 0, 0, nrd, nseq, jd);
    chk({tag, "_rd_cnt"}, nrd, NA);
    chk({tag, "_rd_seq"}, nseq, NA);
    chk({tag, "_done_lat"}, jd, NA + RA + 1);
    chk({tag, "_done_pulses"}, a_done_cnt - c0, 1);
    take_a(p);
    check_ship_a(tag);
    chk({tag, "_exibe"}, a_exibe, 1);
    chk({tag, "_jog"}, a_jog_vga, p[0]);
  endtask

  initial begin
    int nrd, nseq, jd, c0;
    rst_n = 1'b0;
    {a_rdy_pos, a_rdy_exec, a_jog_pos, a_jog_exec, a_fs} = '0;
    {b_rdy_pos, b_rdy_exec, b_jog_pos, b_jog_exec, b_fs} = '0;
    for (int i = 0; i < 32; i++) begin
      mem_a[1][i] = 64'h1 << i;
      mem_a[0][i] = {$urandom, $urandom};
      mem_b[0][i] = {$urandom, $urandom};
      mem_b[1][i] = {$urandom, $urandom};
    end
    for (int i = 0; i < NA; i++) exp_a[i] = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_mem_rd", a_mem_rd, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_jog", a_jog_vga, 0);
    chk("rst_exibe", a_exibe, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovr", a_ovr, 0);
    chk("rst_ship", |a_ship, 0);
    chk("rst_b_ship", |b_ship, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_rd", a_mem_rd, 0);

    // Placement, player 1, word i = 1 << i
    mode_pos = 1'b1;
    a_rdy_pos = 1'b1;
    a_jog_pos = 1'b1;
    repeat (2) tick();
    chk("armed_jog", a_jog_vga, 1);
    chk("armed_exibe", a_exibe, 0);
    full_sweep_a("onehot", 1);
    chk("onehot_rec10", a_ship[10*DW +: DW], 64'h400);

    // Random contents and random idle gaps between frames
    for (int k = 0; k < 3; k++) begin
      fill_a(1);
      repeat ($urandom_range(0, 4)) tick();
      full_sweep_a($sformatf("rnd%0d", k), 1);
    end

    // Second strobe during DRAIN: ignored, flagged until IDLE
    fill_a(1);
    sweep_a(0, 0, NA + 1, nrd, nseq, jd);
    chk("ovr_rd_cnt", nrd, NA);
    chk("ovr_done_lat", jd, NA + RA + 1);
    take_a(1);
    check_ship_a("ovr");
    chk("ovr_flag", a_ovr, 1);
    repeat (3) tick();
    chk("ovr_sticky", a_ovr, 1);
    a_rdy_pos = 1'b0;
    tick();
    chk("idle_ovr_clr", a_ovr, 0);
    chk("idle_exibe", a_exibe, 0);
    clear_exp_on_idle();
    check_ship_a("idle");

    // Both readys: placement wins
    a_jog_pos = 1'b0;
    a_jog_exec = 1'b1;
    a_rdy_pos = 1'b1;
    a_rdy_exec = 1'b1;
    tick();
    chk("both_jog", a_jog_vga, 0);
    fill_a(0);
    full_sweep_a("both", 0);
    a_jog_exec = 1'b0;
    tick();
    chk("both_inact_jog", a_jog_vga, 0);
    chk("both_inact_exibe", a_exibe, 1);
    a_rdy_exec = 1'b0;
    tick();
    chk("both_exec_drop_exibe", a_exibe, 1);

    // Game mode, ready dropped in sweep cycle 5
    a_rdy_pos = 1'b0;
    tick();
    clear_exp_on_idle();
    mode_pos = 1'b0;
    a_jog_exec = 1'b1;
    a_rdy_exec = 1'b1;
    tick();
    chk("exec_jog", a_jog_vga, 1);
    fill_a(1);
    full_sweep_a("exec", 1);
    fill_a(1);
    sweep_a(5, 0, 0, nrd, nseq, jd);
    chk("drop_rd_cnt", nrd, 5);
    chk("drop_rd_seq", nseq, 5);
    chk("drop_no_done", jd, 0);
    chk("drop_exibe", a_exibe, 0);
    chk("drop_mem_rd", a_mem_rd, 0);
    clear_exp_on_idle();
    check_ship_a("drop");

    // Player toggled mid-ISSUE: abort, then sweep the new player
    a_rdy_exec = 1'b1;
    tick();
    fill_a(1);
    full_sweep_a("pre_tog", 1);
    fill_a(1);
    sweep_a(0, 4, 0, nrd, nseq, jd);
    chk("tog_rd_cnt", nrd, 4);
    chk("tog_no_done", jd, 0);
    chk("tog_jog", a_jog_vga, 0);
    chk("tog_exibe", a_exibe, 0);
    check_ship_a("tog_keep");
    fill_a(0);
    full_sweep_a("tog_new", 0);

    // Reset mid-sweep clears outputs asynchronously; partial shadow never committed
    c0 = a_done_cnt;
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_rd", a_mem_rd, 0);
    chk("arst_mem_addr", a_mem_addr, 0);
    chk("arst_jog", a_jog_vga, 0);
    chk("arst_exibe", a_exibe, 0);
    chk("arst_ovr", a_ovr, 0);
    chk("arst_ship", |a_ship, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("arst_no_done", a_done_cnt - c0, 0);
    chk("arst_ship_after", |a_ship, 0);
    chk("arst_exibe_after", a_exibe, 0);

    // Small instance: 4 ships, read latency 3
    b_rdy_pos = 1'b1;
    repeat (2) tick();
    nrd = 0; nseq = 0; jd = 0;
    b_fs = 1'b1;
    tick();
    b_fs = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (b_mem_rd) begin
        nrd++;
        if (int'(b_mem_addr) == j - 1) nseq++;
      end
      if (b_done && jd == 0) jd = j;
      tick();
    end
    chk("b_rd_cnt", nrd, NB);
    chk("b_rd_seq", nseq, NB);
    chk("b_done_lat", jd, NB + RB + 1);
    for (int i = 0; i < NB; i++)
      chk($sformatf("b_rec%0d", i), b_ship[i*DW +: DW], mem_b[0][i]);
    chk("b_exibe", b_exibe, 1);
    chk("b_ovr", b_ovr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
